ssd_result_display: RTL and testbench

SSD_RESULT_DISPLAY -- requirements
Module: ssd_result_display

---
 rtl/ssd_result_display.sv | 155 +++++++++++++++
 tb/tb_ssd_result_display.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ssd_result_display.sv
// Converts a latched 16-bit result to five BCD digits (double dabble, one step per clock)
// and multiplexes them onto an 8-digit active-low seven-segment display.
module ssd_result_display #(
  parameter int unsigned SCAN_W = 17
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] Value,
  input  logic        Err,
  output logic        Busy,
  output logic        Done,
  output logic [19:0] Bcd,
  output logic [7:0]  An,
  output logic [7:0]  Cathodes
);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [15:0]       sr;
  logic [19:0]       acc, acc_adj;
  logic [3:0]        step;
  logic              err_q, disp_err;
  logic [SCAN_W+2:0] scan;
  logic [2:0]        idx;
  logic [3:0]        cur_digit;
  logic [4:0]        show;
  logic [7:0]        an_nxt, cath_nxt;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'h03;
      4'd1:    seg7 = 8'h9F;
      4'd2:    seg7 = 8'h25;
      4'd3:    seg7 = 8'h0D;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h49;
      4'd6:    seg7 = 8'h41;
      4'd7:    seg7 = 8'h1F;
      4'd8:    seg7 = 8'h01;
      4'd9:    seg7 = 8'h09;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Start) state_nxt = S_CONV;
      S_CONV:  if (step == 4'd15) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign Busy = (state != S_IDLE);

  always_comb begin
    acc_adj = acc;
    for (int unsigned i = 0; i < 5; i++) begin
      if (acc[i*4 +: 4] >= 4'd5) acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
    end
  end

  // Done and Bcd are registered in the DONE cycle, so they appear 17 edges after Start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sr       <= '0;
      acc      <= '0;
      step     <= '0;
      err_q    <= 1'b0;
      disp_err <= 1'b0;
      Bcd      <= '0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: if (Start) begin
          sr    <= Value;
          err_q <= Err;
          acc   <= '0;
          step  <= '0;
        end
        S_CONV: begin
          {acc, sr} <= {acc_adj[18:0], sr, 1'b0};
          step      <= step + 4'd1;
        end
        S_DONE: begin
          Bcd      <= acc;
          disp_err <= err_q;
          Done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign idx = scan[SCAN_W+2:SCAN_W];

  always_comb begin
    case (idx)
      3'd0:    cur_digit = Bcd[3:0];
      3'd1:    cur_digit = Bcd[7:4];
      3'd2:    cur_digit = Bcd[11:8];
      3'd3:    cur_digit = Bcd[15:12];
      3'd4:    cur_digit = Bcd[19:16];
      default: cur_digit = '0;
    endcase
  end

  // A digit is lit if it or any more significant digit is nonzero; digit 0 always lit.
  always_comb begin
    show    = '0;
    show[4] = (Bcd[19:16] != 4'd0);
    show[3] = show[4] | (Bcd[15:12] != 4'd0);
    show[2] = show[3] | (Bcd[11:8] != 4'd0);
    show[1] = show[2] | (Bcd[7:4] != 4'd0);
    show[0] = 1'b1;
  end

  always_comb begin
    an_nxt   = '1;
    cath_nxt = '1;
    if (disp_err) begin
      case (idx)
        3'd2: begin an_nxt[2] = 1'b0; cath_nxt = 8'h61; end
        3'd1: begin an_nxt[1] = 1'b0; cath_nxt = 8'hF5; end
        3'd0: begin an_nxt[0] = 1'b0; cath_nxt = 8'hF5; end
        default: ;
      endcase
    end else if (idx < 3'd5 && show[idx]) begin
      an_nxt[idx] = 1'b0;
      cath_nxt    = seg7(cur_digit);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      scan     <= '0;
      An       <= '1;
      Cathodes <= '1;
    end else begin
      scan     <= scan + 1'b1;
      An       <= an_nxt;
      Cathodes <= cath_nxt;
    end
  end

endmodule

// File: tb/tb_ssd_result_display.sv
// Directed bench for ssd_result_display with a short scan period (SCAN_W=2).
module tb_ssd_result_display;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [15:0] Value = '0;
  logic        Err = 1'b0;
  logic        Busy, Done;
  logic [19:0] Bcd;
  logic [7:0]  An, Cathodes;

  int errors = 0;
  int checks = 0;

  logic [7:0] seen_low;
  logic [7:0] seen_cath [8];
  logic       multi_low;
  int         done_at, done_cnt, busy_cnt;

  ssd_result_display #(.SCAN_W(2)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Value(Value), .Err(Err),
    .Busy(Busy), .Done(Done), .Bcd(Bcd), .An(An), .Cathodes(Cathodes)
  );

  always #5 Clk = ~Clk;

  task automatic capture(input int n);
    seen_low  = '0;
    multi_low = 1'b0;
    for (int j = 0; j < 8; j++) seen_cath[j] = 8'hFF;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      if ($countones(~An) > 1) multi_low = 1'b1;
      for (int j = 0; j < 8; j++) begin
        if (!An[j]) begin
          seen_low[j]  = 1'b1;
          seen_cath[j] = Cathodes;
        end
      end
    end
  endtask

  // Starts a conversion and watches 40 edges; optionally retries Start at edge 5.
  task automatic run_conv(input logic [15:0] v, input logic e, input logic second, input logic [15:0] v2);
    Value = v; Err = e; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    busy_cnt = Busy ? 1 : 0;
    done_at  = -1;
    done_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (second && k == 5) begin Value = v2; Start = 1'b1; end
      if (Busy) busy_cnt++;
      if (Done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
    end
    Start = 1'b0;
  endtask

  task automatic check_display(input string name, input logic [7:0] exp_low,
                               input logic [7:0] c4, input logic [7:0] c3, input logic [7:0] c2,
                               input logic [7:0] c1, input logic [7:0] c0);
    logic [7:0] exp_c [5];
    exp_c[0] = c0; exp_c[1] = c1; exp_c[2] = c2; exp_c[3] = c3; exp_c[4] = c4;
    capture(48);
    checks++;
    if (seen_low !== exp_low || multi_low !== 1'b0) begin
      errors++;
      $display("FAIL %s anodes: lit=%h multi=%b expected lit=%h multi=0", name, seen_low, multi_low, exp_low);
    end
    for (int j = 0; j < 5; j++) begin
      if (exp_low[j]) begin
        checks++;
        if (seen_cath[j] !== exp_c[j]) begin
          errors++;
          $display("FAIL %s cathodes An[%0d]: got %h expected %h", name, j, seen_cath[j], exp_c[j]);
        end
      end
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    @(negedge Clk); @(negedge Clk);
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Bcd !== 20'h0 || An !== 8'hFF || Cathodes !== 8'hFF) begin
      errors++;
      $display("FAIL reset_state: Busy=%b Done=%b Bcd=%h An=%h Cath=%h expected 0 0 00000 FF FF",
               Busy, Done, Bcd, An, Cathodes);
    end
    Reset = 1'b0;
    @(negedge Clk);
    checks++;
    if (An !== 8'hFE || Cathodes !== 8'h03) begin
      errors++;
      $display("FAIL reset_first_digit: An=%h Cath=%h expected FE 03", An, Cathodes);
    end
    check_display("reset_idle", 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03);
    checks++;
    if (Bcd !== 20'h0) begin
      errors++;
      $display("FAIL reset_bcd: got %h expected 00000", Bcd);
    end
  endtask

  task automatic test_max_value;
    run_conv(16'd65535, 1'b0, 1'b0, 16'd0);
    checks++;
    if (done_at !== 17 || done_cnt !== 1) begin
      errors++;
      $display("FAIL max_done_timing: done_at=%0d count=%0d expected 17 1", done_at, done_cnt);
    end
    checks++;
    if (busy_cnt !== 17) begin
      errors++;
      $display("FAIL max_busy_len: got %0d expected 17", busy_cnt);
    end
    checks++;
    if (Bcd !== 20'h65535) begin
      errors++;
      $display("FAIL max_bcd: got %h expected 65535", Bcd);
    end
    check_display("max_display", 8'h1F, 8'h41, 8'h49, 8'h49, 8'h0D, 8'h49);
  endtask

  task automatic test_blanking;
    run_conv(16'd907, 1'b0, 1'b0, 16'd0);
    checks++;
    if (Bcd !== 20'h00907) begin
      errors++;
      $display("FAIL blank_bcd: got %h expected 00907", Bcd);
    end
    check_display("blank_display", 8'h07, 8'hFF, 8'hFF, 8'h09, 8'h03, 8'h1F);
  endtask

  task automatic test_back_to_back;
    run_conv(16'd42, 1'b0, 1'b1, 16'd7);
    checks++;
    if (done_cnt !== 1 || done_at !== 17) begin
      errors++;
      $display("FAIL b2b_done: count=%0d at=%0d expected 1 at 17", done_cnt, done_at);
    end
    checks++;
    if (Bcd !== 20'h00042) begin
      errors++;
      $display("FAIL b2b_bcd: got %h expected 00042", Bcd);
    end
  endtask

  task automatic test_error;
    run_conv(16'd12, 1'b1, 1'b0, 16'd0);
    checks++;
    if (Bcd !== 20'h00012) begin
      errors++;
      $display("FAIL err_bcd: got %h expected 00012", Bcd);
    end
    check_display("err_display", 8'h07, 8'hFF, 8'hFF, 8'h61, 8'hF5, 8'hF5);
  endtask

  task automatic test_abort;
    Value = 16'd1234; Err = 1'b0; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    done_cnt = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge Clk);
      if (Done) done_cnt++;
    end
    Reset = 1'b1;
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b0 || Bcd !== 20'h0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: Busy=%b Bcd=%h Done=%b expected 0 00000 0", Busy, Bcd, Done);
    end
    Reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge Clk);
      if (Done) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt);
    end
    run_conv(16'd1234, 1'b0, 1'b0, 16'd0);
    checks++;
    if (Bcd !== 20'h01234 || done_at !== 17) begin
      errors++;
      $display("FAIL abort_rerun: Bcd=%h done_at=%0d expected 01234 17", Bcd, done_at);
    end
    check_display("rerun_display", 8'h0F, 8'hFF, 8'h9F, 8'h25, 8'h0D, 8'h99);
  endtask

  initial begin
    test_reset();
    test_max_value();
    test_blanking();
    test_back_to_back();
    test_error();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
